multicycle_control_unit: RTL and testbench

Multi-cycle main control for the RV32I core, replacing the single-cycle opcode decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states, with optional wait-states on a memory ready handshake. It drives the shared-ALU/shared-memory datapath, traps on unsupported opcodes, and counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_control_unit_classifier.sv | 22 ++
 rtl/multicycle_control_unit.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: FSM states,
// opcode constants, op classes and datapath mux/ALU selector values.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MEMWB  = 3'd4,
        S_ALUWB  = 3'd5,
        S_BRANCH = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_IALU    = 3'd2,
        CLS_LW      = 3'd3,
        CLS_SW      = 3'd4,
        CLS_BEQ     = 3'd5
    } opclass_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_control_unit_classifier.sv
// Opcode to op-class decode; anything unrecognised maps to CLS_ILLEGAL.
// Also used by the datapath immediate generator.
module opcode_classifier
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = CLS_ILLEGAL;
        case (opcode)
            OP_R:    opclass = CLS_R;
            OP_IALU: opclass = CLS_IALU;
            OP_LW:   opclass = CLS_LW;
            OP_SW:   opclass = CLS_SW;
            OP_BEQ:  opclass = CLS_BEQ;
            default: opclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions over a shared ALU/memory datapath,
// with memory wait-states, an absorbing illegal-opcode trap and a retire counter.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_WAIT_EN = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUOP_W-1:0] aluop,
    output logic               pcsource,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret,
    output logic [2:0]         state
);

    state_t          state_q, state_d;
    opclass_t        class_q, class_dec;
    logic [CNT_W-1:0] instret_q;
    logic            accept;
    logic            retire;
    logic [1:0]      aluop_c;

    opcode_classifier u_classifier (
        .opcode  (opcode),
        .opclass (class_dec)
    );

    assign accept  = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign state   = state_q;
    assign instret = instret_q;
    assign aluop   = ALUOP_W'(aluop_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= CLS_ILLEGAL;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                class_q <= class_dec;
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next-state, retire and outputs; the reset term both masks every control
    // and suppresses retirement so an aborted instruction leaves no trace.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        pc_write = 1'b0;
        ir_write = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RS2;
        aluop_c  = ALUOP_ADD;
        pcsource = PCSRC_ALU;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcb  = SRCB_FOUR;
                ir_write = accept;
                pc_write = accept;
                if (accept)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM;
                case (class_dec)
                    CLS_R, CLS_IALU, CLS_LW, CLS_SW: state_d = S_EXEC;
                    CLS_BEQ:                         state_d = S_BRANCH;
                    default:                         state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alusrca = 1'b1;
                alusrcb = (class_q == CLS_R) ? SRCB_RS2 : SRCB_IMM;
                case (class_q)
                    CLS_R:          begin aluop_c = ALUOP_RFUNCT; state_d = S_ALUWB; end
                    CLS_IALU:       begin aluop_c = ALUOP_IFUNCT; state_d = S_ALUWB; end
                    CLS_LW, CLS_SW: begin aluop_c = ALUOP_ADD;    state_d = S_MEM;   end
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                iord     = 1'b1;
                memread  = (class_q == CLS_LW);
                memwrite = (class_q == CLS_SW);
                if (accept) begin
                    if (class_q == CLS_LW) begin
                        state_d = S_MEMWB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_RS2;
                aluop_c  = ALUOP_SUB;
                pcsource = PCSRC_ALUOUT;
                pc_write = zero;
                state_d  = S_FETCH;
                retire   = 1'b1;
            end
            default: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
        endcase

        if (reset) begin
            retire   = 1'b0;
            pc_write = 1'b0;
            ir_write = 1'b0;
            iord     = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = SRCB_RS2;
            aluop_c  = ALUOP_ADD;
            pcsource = PCSRC_ALU;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised bench for multicycle_control_unit against a per-instruction
// phase-list model; a second instance covers counter wrap and ignored mem_ready.
module tb_multicycle_control_unit;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ILL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // primary instance: default parameters
    logic        reset, zero, mem_ready;
    logic [6:0]  opcode;
    logic        pc_write, ir_write, iord, memread, memwrite, memtoreg, regwrite, alusrca, pcsource, illegal;
    logic [1:0]  alusrcb, aluop;
    logic [31:0] instret;
    logic [2:0]  state;
    logic [13:0] ctrl0;

    multicycle_control_unit #(.ALUOP_W(2), .MEM_WAIT_EN(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .illegal(illegal),
        .instret(instret), .state(state)
    );

    assign ctrl0 = {pc_write, ir_write, iord, memread, memwrite, memtoreg, regwrite,
                    alusrca, alusrcb, aluop, pcsource, illegal};

    // secondary instance: 4-bit counter, memory handshake disabled
    logic        reset1, zero1, mem_ready1;
    logic [6:0]  opcode1;
    logic        pc_write1, ir_write1, iord1, memread1, memwrite1, memtoreg1, regwrite1, alusrca1, pcsource1, illegal1;
    logic [1:0]  alusrcb1, aluop1;
    logic [3:0]  instret1;
    logic [2:0]  state1;

    multicycle_control_unit #(.ALUOP_W(2), .MEM_WAIT_EN(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset1), .opcode(opcode1), .zero(zero1), .mem_ready(mem_ready1),
        .pc_write(pc_write1), .ir_write(ir_write1), .iord(iord1), .memread(memread1),
        .memwrite(memwrite1), .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .aluop(aluop1), .pcsource(pcsource1), .illegal(illegal1),
        .instret(instret1), .state(state1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // reference model: an instruction is a list of phases; FETCH/MEM repeat while not ready
    int          cls_cur;
    int          seq[$];
    int          pos;
    logic [31:0] m_instret;

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BEQ;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic logic [13:0] exp_ctrl(input int st, input int cls, input bit rdy, input bit z);
        bit pcw = 0, irw = 0, ad = 0, mr = 0, mw = 0, m2r = 0, rw = 0, sa = 0, pcs = 0, ill = 0;
        logic [1:0] sb = 2'b00, op = 2'b00;
        case (st)
            0: begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1: sb = 2'b10;
            2: begin
                sa = 1;
                sb = (cls == C_R) ? 2'b00 : 2'b10;
                op = (cls == C_R) ? 2'b10 : (cls == C_I) ? 2'b11 : 2'b00;
            end
            3: begin ad = 1; mr = (cls == C_LW); mw = (cls == C_SW); end
            4: begin rw = 1; m2r = 1; end
            5: rw = 1;
            6: begin sa = 1; op = 2'b01; pcs = 1; pcw = z; end
            default: ill = 1;
        endcase
        return {pcw, irw, ad, mr, mw, m2r, rw, sa, sb, op, pcs, ill};
    endfunction

    task automatic start_instr(input logic [6:0] op);
        opcode  = op;
        cls_cur = classify(op);
        case (cls_cur)
            C_R, C_I: seq = '{0, 1, 2, 5};
            C_LW:     seq = '{0, 1, 2, 3, 4};
            C_SW:     seq = '{0, 1, 2, 3};
            C_BEQ:    seq = '{0, 1, 6};
            default:  seq = '{0, 1, 7};
        endcase
        pos = 0;
    endtask

    // called just after a negedge; returns just after the following negedge
    task automatic cyc(input bit rdy, input bit z);
        int st;
        mem_ready = rdy;
        zero      = z;
        if (pos >= 2) opcode = 7'($urandom);
        #1;
        st = seq[pos];
        chk("state", 64'(state), 64'(st));
        chk("ctrl", 64'(ctrl0), 64'(exp_ctrl(st, cls_cur, rdy, z)));
        chk("instret", 64'(instret), 64'(m_instret));
        @(posedge clk);
        if (st != 7 && !((st == 0 || st == 3) && !rdy)) begin
            pos++;
            if (pos == seq.size()) m_instret++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            #1;
            chk("rst_ctrl", 64'(ctrl0), 64'd0);
            if (i > 0) begin
                chk("rst_state", 64'(state), 64'd0);
                chk("rst_instret", 64'(instret), 64'd0);
            end
            @(posedge clk);
            @(negedge clk);
        end
        reset     = 1'b0;
        m_instret = '0;
    endtask

    task automatic run_instr(input logic [6:0] op);
        int  guard;
        bit  rdy;
        start_instr(op);
        guard = 0;
        while (pos < seq.size()) begin
            rdy = (guard >= 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cyc(rdy, 1'($urandom));
            guard++;
        end
    endtask

    logic [6:0] legal_ops [5];

    initial begin
        legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; m_instret = '0;
        reset1 = 1'b1; zero1 = 1'b0; mem_ready1 = 1'b0; opcode1 = 7'b0100011;
        start_instr(7'b0110011);
        @(negedge clk);
        do_reset(2);

        // R-type, memory always ready
        start_instr(7'b0110011);
        repeat (4) cyc(1'b1, 1'b0);

        // LW with two MEM wait cycles
        start_instr(7'b0000011);
        cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0);

        // BEQ taken then not taken
        start_instr(7'b1100011);
        repeat (3) cyc(1'b1, 1'b1);
        start_instr(7'b1100011);
        repeat (3) cyc(1'b1, 1'b0);

        // random instruction mix with random waits, zero and post-decode opcode noise
        for (int i = 0; i < 60; i++)
            run_instr(legal_ops[$urandom_range(0, 4)]);

        // reset for 2 cycles in the middle of EXEC
        start_instr(7'b0110011);
        cyc(1, 0); cyc(1, 0);
        do_reset(2);
        for (int i = 0; i < 5; i++)
            run_instr(legal_ops[$urandom_range(0, 4)]);

        // illegal opcode traps and stays trapped
        start_instr(7'b1111111);
        repeat (22) cyc(1'($urandom), 1'($urandom));
        do_reset(1);
        run_instr(7'b0100011);
        run_instr(7'b0110011);

        // secondary instance: 17 SW back to back with mem_ready held low
        reset1 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            for (int c = 0; c < 4; c++) begin
                #1;
                chk("w_state", 64'(state1), 64'(c));
                if (c == 0) begin
                    chk("w_irwrite", 64'(ir_write1), 64'd1);
                    chk("w_instret", 64'(instret1), 64'(i % 16));
                end
                if (c == 3) chk("w_memwrite", 64'(memwrite1), 64'd1);
                @(posedge clk);
                @(negedge clk);
            end
        end
        #1;
        chk("w_wrap", 64'(instret1), 64'd1);
        chk("w_final_state", 64'(state1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
